uart_tx_dev: RTL

//  Bus-side responder on the bridge bus: the CPU writes bytes through the bridge, this

---
 rtl/uart_tx_dev.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_dev.sv
// Bridge-bus UART transmitter: CPU-written bytes queue in a small FIFO and are
// serialised on txd as 8N1 frames; IRQ signals that all queued data has gone out.
module uart_tx_dev #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            en_q, en_d;
    logic            ie_q, ie_d;
    logic [15:0]     div_q, div_d;
    logic [7:0]      fifo_mem_q [FIFO_DEPTH];

    logic [1:0]      reg_sel;
    logic            push_req;
    logic            push_ok;
    logic            pop;
    logic            full;
    logic            empty;
    logic            busy;
    logic            can_start;
    logic            timer_done;
    logic [15:0]     reload;
    logic            unused_bits;

    assign unused_bits = ^{Addr[31:4], Din[31:16]};

    assign reg_sel    = Addr[3:2];
    assign push_req   = WE && (reg_sel == 2'd0);
    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign busy       = (state_q != S_IDLE);
    assign can_start  = en_q && !empty;
    assign timer_done = (timer_q == 16'd0);
    // A divisor of zero runs at one clock per bit rather than stalling.
    assign reload     = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (can_start) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem_q[rd_ptr_q];
                    timer_d = reload;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (timer_done) begin
                    timer_d   = reload;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_DATA: begin
                if (timer_done) begin
                    timer_d = reload;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_STOP: begin
                if (timer_done) begin
                    if (can_start) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem_q[rd_ptr_q];
                        timer_d = reload;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // txd is registered, so the line trails the state register by one clock.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    // A pop frees the head slot in the same cycle, so a push into a full FIFO is kept.
    always_comb begin
        push_ok  = push_req && (!full || pop);
        wr_ptr_d = push_ok ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        ovf_d    = ovf_q;
        if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end else if (WE && (reg_sel == 2'd1)) begin
            ovf_d = 1'b0;
        end
        en_d  = en_q;
        ie_d  = ie_q;
        div_d = div_q;
        if (WE && (reg_sel == 2'd2)) begin
            en_d = Din[0];
            ie_d = Din[1];
        end
        if (WE && (reg_sel == 2'd3)) begin
            div_d = Din[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            txd_q     <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            div_q     <= DIV_RESET;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            en_q      <= en_d;
            ie_q      <= ie_d;
            div_q     <= div_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= Din[7:0];
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (reg_sel)
            2'd0: Dout = 32'd0;
            2'd1: Dout = {24'd0, 4'(count_q), ovf_q, busy, empty, full};
            2'd2: Dout = {30'd0, ie_q, en_q};
            2'd3: Dout = {16'd0, div_q};
            default: Dout = 32'd0;
        endcase
    end

    assign IRQ = ie_q && empty && !busy;
    assign txd = txd_q;

endmodule
